spectrum_ram_arbiter: RTL

SPECTRUM_RAM_ARBITER -- requirements
Module: spectrum_ram_arbiter

---
 rtl/spectrum_ram_arbiter_pkg.sv | 27 ++
 rtl/spectrum_ram_arbiter_rd_tag_pipe.sv | 31 +++
 rtl/spectrum_ram_arbiter.sv | 121 ++++++++++++
 3 files changed

// File: rtl/spectrum_ram_arbiter_pkg.sv
// Shared spectrum definitions: bin RAM geometry, frame length and
// the reader-tag encoding used by the RAM arbiter and its read pipe.
package spectrum_ram_arbiter_pkg;

    localparam int unsigned SPEC_ADDR_W    = 9;
    localparam int unsigned SPEC_DATA_W    = 36;
    localparam int unsigned SPEC_FRAME_LEN = 1 << SPEC_ADDR_W;

    // Owner of an outstanding RAM read
    typedef enum logic [1:0] {
        TAG_NONE = 2'b00,
        TAG_A    = 2'b01,
        TAG_S    = 2'b10
    } rd_tag_t;

    typedef enum logic {
        ST_IDLE     = 1'b0,
        ST_WR_BURST = 1'b1
    } arb_state_t;

    // Round-robin priority pointer between the two readers
    typedef enum logic {
        PTR_A = 1'b0,
        PTR_S = 1'b1
    } rr_ptr_t;

endpackage

// File: rtl/spectrum_ram_arbiter_rd_tag_pipe.sv
// Delay line carrying the reader tag alongside the RAM read latency.
module rd_tag_pipe
    import spectrum_ram_arbiter_pkg::*;
#(
    parameter int unsigned RD_LAT = 1
) (
    input  logic    clk,
    input  logic    reset,
    input  rd_tag_t tag_in,
    output rd_tag_t tag_out
);

    rd_tag_t pipe_q [RD_LAT];

    // Shift tags one stage per cycle; reset drops everything in flight
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < RD_LAT; i++) begin
                pipe_q[i] <= TAG_NONE;
            end
        end else begin
            pipe_q[0] <= tag_in;
            for (int unsigned i = 1; i < RD_LAT; i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
        end
    end

    assign tag_out = pipe_q[RD_LAT-1];

endmodule

// File: rtl/spectrum_ram_arbiter.sv
// Single-port spectrum RAM arbiter: FFT writer (with frame-burst lock)
// against two round-robin readers, read data steered by a tag pipe.
module spectrum_ram_arbiter
    import spectrum_ram_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W = SPEC_ADDR_W,
    parameter int unsigned DATA_W = SPEC_DATA_W,
    parameter int unsigned RD_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_gnt,
    input  logic              a_req,
    input  logic [ADDR_W-1:0] a_addr,
    output logic              a_gnt,
    output logic              a_valid,
    input  logic              s_req,
    input  logic [ADDR_W-1:0] s_addr,
    output logic              s_gnt,
    output logic              s_valid,
    output logic [DATA_W-1:0] rd_data,
    output logic              frame_done,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_din,
    output logic              ram_we,
    input  logic [DATA_W-1:0] ram_dout
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

    arb_state_t        state_q, state_d;
    rr_ptr_t           ptr_q, ptr_d;
    logic [ADDR_W-1:0] addr_q;
    logic              frame_done_d;
    rd_tag_t           tag_in, tag_out;

    // Grant selection and next-state; grants are held off during reset
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        wr_gnt  = 1'b0;
        a_gnt   = 1'b0;
        s_gnt   = 1'b0;
        if (!reset) begin
            case (state_q)
                ST_IDLE: begin
                    if (wr_req) begin
                        wr_gnt = 1'b1;
                        if (wr_addr == '0) begin
                            state_d = ST_WR_BURST;
                        end
                    end else if (a_req && (!s_req || ptr_q == PTR_A)) begin
                        a_gnt = 1'b1;
                        ptr_d = PTR_S;
                    end else if (s_req) begin
                        s_gnt = 1'b1;
                        ptr_d = PTR_A;
                    end
                end
                ST_WR_BURST: begin
                    wr_gnt = wr_req;
                    if (wr_req && wr_addr == LAST_ADDR) begin
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    assign frame_done_d = (state_q == ST_WR_BURST) && wr_gnt && (wr_addr == LAST_ADDR);

    // RAM address follows the granted requester, otherwise holds the last one
    always_comb begin
        if (wr_gnt) begin
            ram_addr = wr_addr;
        end else if (a_gnt) begin
            ram_addr = a_addr;
        end else if (s_gnt) begin
            ram_addr = s_addr;
        end else begin
            ram_addr = addr_q;
        end
    end

    assign ram_we  = wr_gnt;
    assign ram_din = wr_data;
    assign tag_in  = a_gnt ? TAG_A : (s_gnt ? TAG_S : TAG_NONE);

    // State, pointer, held address and frame pulse registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            ptr_q      <= PTR_A;
            addr_q     <= '0;
            frame_done <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            addr_q     <= ram_addr;
            frame_done <= frame_done_d;
        end
    end

    rd_tag_pipe #(
        .RD_LAT (RD_LAT)
    ) u_rd_tag_pipe (
        .clk     (clk),
        .reset   (reset),
        .tag_in  (tag_in),
        .tag_out (tag_out)
    );

    assign a_valid = (tag_out == TAG_A);
    assign s_valid = (tag_out == TAG_S);
    assign rd_data = ram_dout;

endmodule
